decision_arbiter: RTL and testbench

- Parametrised, registered successor to the team's combinational 4-input decision block.
- Takes N request lines and issues one registered one-hot grant, plus a binary index of the granted requester.
- Supports fixed-priority mode (highest index wins) and round-robin mode.
- Each grant is held until the requester acknowledges it or drops its request.
- Sits between request sources and a shared resource.

---
 rtl/decision_arbiter.sv | 152 +++++++++++++++
 tb/tb_decision_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/decision_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : decision_arbiter
//  Brief    : Registered N-way arbiter with fixed-priority / round-robin modes
//             and grant hold until ack or withdrawal. Optional hold timeout is
//             enabled by defining DECISION_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module decision_arbiter #(
    parameter int N       = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             ack,
    input  logic             mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
`ifdef DECISION_ARB_TIMEOUT_EN
    output logic             timeout_pulse,
`endif
    output logic             gnt_valid
);

    if (N < 2 || N > 16 || (1 << IDX_W) < N) begin : g_bad_width
        $error("decision_arbiter: illegal N/IDX_W combination");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("decision_arbiter: TIMEOUT out of range");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] win_idx;
    logic             found;
    int               rr_pos;

`ifdef DECISION_ARB_TIMEOUT_EN
    localparam logic [7:0] C_HOLD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;
`endif

    // Fixed priority lets the last set bit win; round-robin takes the first hit after last_q.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        rr_pos  = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) win_idx = IDX_W'(i);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                rr_pos = (int'(last_q) + k) % N;
                if (!found && req[rr_pos]) begin
                    win_idx = IDX_W'(rr_pos);
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef DECISION_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d        = ST_GRANT;
                    idx_d          = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
`ifdef DECISION_ARB_TIMEOUT_EN
                    cnt_d          = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    last_d  = idx_q;
                end else if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else begin
`ifdef DECISION_ARB_TIMEOUT_EN
                    if (cnt_q == C_HOLD_LAST) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        last_d  = idx_q;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(N - 1);
`ifdef DECISION_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            pulse_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef DECISION_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == ST_GRANT);
`ifdef DECISION_ARB_TIMEOUT_EN
    assign timeout_pulse = pulse_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decision_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decision_arbiter
//  Brief    : Directed self-checking bench for decision_arbiter (N=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decision_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
`ifdef DECISION_ARB_TIMEOUT_EN
    logic       timeout_pulse;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rr [5] = '{0, 1, 2, 3, 0};

    decision_arbiter #(.N(4), .IDX_W(2), .TIMEOUT(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
`ifdef DECISION_ARB_TIMEOUT_EN
        .timeout_pulse (timeout_pulse),
`endif
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; ack = 1'b0; mode = 1'b0;
        cyc(); cyc();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_valid", 32'(gnt_valid), 0);
        check("rst_idx", 32'(gnt_idx), 0);
        rst_n = 1'b1;

        // Fixed priority
        req = 4'b0101; mode = 1'b0;
        cyc();
        check("fp_gnt", 32'(gnt), 32'h4);
        check("fp_idx", 32'(gnt_idx), 2);
        check("fp_valid", 32'(gnt_valid), 1);
        cyc();
        check("fp_hold", 32'(gnt), 32'h4);
        ack = 1'b1; req = 4'b0001;
        cyc();
        check("fp_bubble", 32'(gnt_valid), 0);
        check("fp_bubble_gnt", 32'(gnt), 0);
        check("fp_idx_held", 32'(gnt_idx), 2);
        ack = 1'b0;
        cyc();
        check("fp_second_gnt", 32'(gnt), 32'h1);
        check("fp_second_idx", 32'(gnt_idx), 0);
        ack = 1'b1; req = '0;
        cyc();
        ack = 1'b0;

        // Round-robin fairness from a fresh pointer
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; mode = 1'b1; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("rr_valid", 32'(gnt_valid), 1);
            check("rr_idx", 32'(gnt_idx), 32'(exp_rr[i]));
            ack = 1'b1;
            cyc();
            check("rr_bubble", 32'(gnt_valid), 0);
            ack = 1'b0;
        end
        req = '0;
        cyc();

        // Withdrawal does not advance the pointer (last = 0 here)
        req = 4'b0010;
        cyc();
        check("wd_idx", 32'(gnt_idx), 1);
        req = 4'b0000;
        cyc();
        check("wd_drop", 32'(gnt_valid), 0);
        req = 4'b1010;
        cyc();
        check("wd_regrant", 32'(gnt_idx), 1);
        check("wd_regrant_gnt", 32'(gnt), 32'h2);
        ack = 1'b1; req = '0;
        cyc();
        ack = 1'b0;

        // Asynchronous reset mid-grant
        mode = 1'b0; req = 4'b1000;
        cyc();
        check("ar_gnt", 32'(gnt), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check("ar_gnt_cleared", 32'(gnt), 0);
        check("ar_valid_cleared", 32'(gnt_valid), 0);
        cyc();
        rst_n = 1'b1; req = 4'b1111; mode = 1'b1;
        cyc();
        check("ar_first_rr", 32'(gnt_idx), 0);
        ack = 1'b1;
        cyc();
        ack = 1'b0;

        // Mode switch during grant takes effect at the next arbitration
        mode = 1'b0; req = 4'b1000;
        cyc();
        check("ms_idx3", 32'(gnt_idx), 3);
        mode = 1'b1;
        cyc();
        check("ms_still_held", 32'(gnt), 32'h8);
        ack = 1'b1;
        cyc();
        ack = 1'b0; req = 4'b1001;
        cyc();
        check("ms_rr_idx", 32'(gnt_idx), 0);
        check("ms_rr_gnt", 32'(gnt), 32'h1);
        ack = 1'b1; req = '0;
        cyc();

        // ack while idle is ignored and outputs hold
        cyc(); cyc();
        check("idle_ack_valid", 32'(gnt_valid), 0);
        check("idle_idx_hold", 32'(gnt_idx), 0);
        ack = 1'b0;

`ifdef DECISION_ARB_TIMEOUT_EN
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; mode = 1'b0; req = 4'b0001;
        check("to_rst_pulse", 32'(timeout_pulse), 0);
        cyc();
        for (int i = 0; i < 8; i++) begin
            check("to_held", 32'(gnt_valid), 1);
            check("to_no_pulse", 32'(timeout_pulse), 0);
            cyc();
        end
        check("to_release", 32'(gnt_valid), 0);
        check("to_pulse", 32'(timeout_pulse), 1);
        cyc();
        check("to_regrant", 32'(gnt_valid), 1);
        check("to_regrant_idx", 32'(gnt_idx), 0);
        check("to_pulse_once", 32'(timeout_pulse), 0);
`else
        mode = 1'b0; req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("hold_forever", 32'(gnt_valid), 1);
        end
        check("hold_idx", 32'(gnt_idx), 0);
`endif
        req = '0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
